// File: rtl/focus_search_ctrl.sv
// Autofocus search sequencer: coarse sweep, optional fine sweep, park at the sharpest code.
// Define FOCUS_FINE_PASS_EN to build the fine sweep around the coarse best.
module focus_search_ctrl #(
  parameter int         MAX_STEP      = 1023,
  parameter int         COARSE_INC    = 64,
  parameter int         FINE_INC      = 8,
  parameter int         SETTLE_FRAMES = 1,
  parameter logic [3:0] SLEW          = 4'hF
) (
  input  logic        VIDEO_CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic        FRAME_DONE,
  input  logic [31:0] SHARP,
  input  logic        VCM_ACK,
  output logic        VCM_REQ,
  output logic [15:0] VCM_DATA,
  output logic [9:0]  STEP,
  output logic [9:0]  BEST_STEP,
  output logic [31:0] BEST_SHARP,
  output logic        VCM_END
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE,
    S_SETTLE,
    S_MEASURE,
    S_NEXT,
    S_FINAL_MOVE,
    S_DONE
  } state_e;

  localparam logic [10:0] MAX_W    = 11'(MAX_STEP);
  localparam logic [10:0] COARSE_W = 11'(COARSE_INC);
  localparam logic [10:0] FINE_W   = 11'(FINE_INC);
  localparam logic [7:0]  SETTLE_W = 8'(SETTLE_FRAMES);

  state_e      state_q, state_d;
  logic [9:0]  step_q, step_d;
  logic [9:0]  best_step_q, best_step_d;
  logic [31:0] best_sharp_q, best_sharp_d;
  logic [7:0]  settle_q, settle_d;
  logic        fine_q, fine_d;
  logic        first_q, first_d;

  logic [10:0] inc_w;
  logic [10:0] sum_w;
  logic [10:0] lim_w;

  assign inc_w = fine_q ? FINE_W : COARSE_W;
  assign sum_w = {1'b0, step_q} + inc_w;

`ifdef FOCUS_FINE_PASS_EN
  logic [10:0] hi_q, hi_d;
  logic [10:0] lo_w;
  logic [10:0] hi_w;
  logic [10:0] bsum_w;

  // Window bounds stay 11 bits wide so the clamp sees the true sum.
  assign bsum_w = {1'b0, best_step_q} + COARSE_W;
  assign hi_w   = (bsum_w > MAX_W) ? MAX_W : bsum_w;
  assign lo_w   = ({1'b0, best_step_q} >= COARSE_W) ?
                  ({1'b0, best_step_q} - COARSE_W) : 11'd0;
  assign lim_w  = fine_q ? hi_q : MAX_W;

  always_ff @(posedge VIDEO_CLK) begin
    if (RESET) begin
      hi_q <= 11'd0;
    end else begin
      hi_q <= hi_d;
    end
  end
`else
  assign lim_w = MAX_W;
`endif

  always_ff @(posedge VIDEO_CLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      step_q       <= 10'd0;
      best_step_q  <= 10'd0;
      best_sharp_q <= 32'd0;
      settle_q     <= 8'd0;
      fine_q       <= 1'b0;
      first_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      best_step_q  <= best_step_d;
      best_sharp_q <= best_sharp_d;
      settle_q     <= settle_d;
      fine_q       <= fine_d;
      first_q      <= first_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    best_step_d  = best_step_q;
    best_sharp_d = best_sharp_q;
    settle_d     = settle_q;
    fine_d       = fine_q;
    first_d      = first_q;
`ifdef FOCUS_FINE_PASS_EN
    hi_d         = hi_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          step_d       = 10'd0;
          best_step_d  = 10'd0;
          best_sharp_d = 32'd0;
          fine_d       = 1'b0;
          first_d      = 1'b1;
          state_d      = S_MOVE;
        end
      end
      S_MOVE: begin
        if (VCM_ACK) begin
          settle_d = SETTLE_W;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_q == 8'd0) begin
          state_d = S_MEASURE;
        end else if (FRAME_DONE) begin
          settle_d = settle_q - 8'd1;
          if (settle_q == 8'd1) state_d = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (FRAME_DONE) begin
          // Strict compare: a tie keeps the earlier, lower code.
          if (first_q || (SHARP > best_sharp_q)) begin
            best_step_d  = step_q;
            best_sharp_d = SHARP;
          end
          first_d = 1'b0;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (sum_w <= lim_w) begin
          step_d  = sum_w[9:0];
          state_d = S_MOVE;
        end else if (!fine_q) begin
`ifdef FOCUS_FINE_PASS_EN
          step_d  = lo_w[9:0];
          hi_d    = hi_w;
          fine_d  = 1'b1;
          state_d = S_MOVE;
`else
          step_d  = best_step_q;
          state_d = S_FINAL_MOVE;
`endif
        end else begin
          step_d  = best_step_q;
          state_d = S_FINAL_MOVE;
        end
      end
      S_FINAL_MOVE: begin
        if (VCM_ACK) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign VCM_REQ    = (state_q == S_MOVE) || (state_q == S_FINAL_MOVE);
  assign VCM_END    = (state_q == S_IDLE) || (state_q == S_DONE);
  assign VCM_DATA   = {2'b00, step_q, SLEW};
  assign STEP       = step_q;
  assign BEST_STEP  = best_step_q;
  assign BEST_SHARP = best_sharp_q;

endmodule

// File: tb/tb_focus_search_ctrl.sv
// Randomized bench for focus_search_ctrl against a sweep-level reference model.
// Follows FOCUS_FINE_PASS_EN the same way the design does.
module tb_focus_search_ctrl;

  logic        clk = 1'b0;
  logic        RESET;
  logic        START;
  logic        FRAME_DONE;
  logic [31:0] SHARP;
  logic        VCM_ACK;
  logic        VCM_REQ;
  logic [15:0] VCM_DATA;
  logic [9:0]  STEP;
  logic [9:0]  BEST_STEP;
  logic [31:0] BEST_SHARP;
  logic        VCM_END;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] tab [0:1023];
  logic [15:0] exp_q[$];
  int          exp_best;
  logic [31:0] exp_sharp;

  focus_search_ctrl dut (
    .VIDEO_CLK (clk),
    .RESET     (RESET),
    .START     (START),
    .FRAME_DONE(FRAME_DONE),
    .SHARP     (SHARP),
    .VCM_ACK   (VCM_ACK),
    .VCM_REQ   (VCM_REQ),
    .VCM_DATA  (VCM_DATA),
    .STEP      (STEP),
    .BEST_STEP (BEST_STEP),
    .BEST_SHARP(BEST_SHARP),
    .VCM_END   (VCM_END)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk(input int c);
    logic [9:0] cc;
    cc = c[9:0];
    return {2'b00, cc, 4'hF};
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic fill_tab(input int scen);
    for (int c = 0; c < 1024; c++) begin
      case (scen)
        0: tab[c] = 32'(1000000 - 100 * iabs(c - 304));
        1: tab[c] = 32'd5000;
        2: tab[c] = 32'(1000000 - 100 * c);
        3: tab[c] = 32'($urandom_range(0, 3) * 1000);
        4: tab[c] = 32'(1000000 - 100 * iabs(c - 1000));
        default: tab[c] = $urandom;
      endcase
    end
  endtask

  task automatic visit(input int c, inout int b, inout logic [31:0] bs,
                       inout bit first);
    exp_q.push_back(mk(c));
    if (first || tab[c] > bs) begin
      b  = c;
      bs = tab[c];
    end
    first = 0;
  endtask

  task automatic build_model();
    int          b;
    logic [31:0] bs;
    bit          first;
    b = 0;
    bs = 0;
    first = 1;
    exp_q.delete();
    for (int c = 0; c <= 1023; c += 64) visit(c, b, bs, first);
`ifdef FOCUS_FINE_PASS_EN
    begin
      int lo;
      int hi;
      lo = (b - 64 < 0) ? 0 : b - 64;
      hi = (b + 64 > 1023) ? 1023 : b + 64;
      for (int c = lo; c <= hi; c += 8) visit(c, b, bs, first);
    end
`endif
    exp_q.push_back(mk(b));
    exp_best  = b;
    exp_sharp = bs;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req"}, VCM_REQ, 0);
    check({tag, "_step"}, STEP, 0);
    check({tag, "_data"}, VCM_DATA, 16'h000F);
    check({tag, "_bstep"}, BEST_STEP, 0);
    check({tag, "_bsharp"}, BEST_SHARP, 0);
    check({tag, "_end"}, VCM_END, 1);
  endtask

  task automatic run_search(input int scen, input int stop_at);
    logic [15:0] got[$];
    bit          pend;
    bit          fin;
    logic [15:0] cur;
    int          wc;
    int          fc;
    int          unstable;
    pend = 0;
    fin = 0;
    cur = 16'h000F;
    wc = 0;
    fc = 0;
    unstable = 0;
    fill_tab(scen);
    build_model();
    START = 1'b1;
    tick();
    START = 1'b0;
    check("start_req", VCM_REQ, 1);
    check("start_end", VCM_END, 0);
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (VCM_END) begin
        fin = 1;
        break;
      end
      if (stop_at > 0 && got.size() >= stop_at) begin
        fin = 1;
        break;
      end
      VCM_ACK = 1'b0;
      FRAME_DONE = 1'b0;
      SHARP = $urandom;
      START = ($urandom_range(0, 31) == 0);
      if (VCM_REQ) begin
        if (!pend) begin
          pend = 1;
          cur = VCM_DATA;
          got.push_back(VCM_DATA);
          wc = $urandom_range(0, 4);
        end else if (VCM_DATA !== cur) begin
          unstable++;
        end
        if (wc == 0) begin
          VCM_ACK = 1'b1;
          pend = 0;
        end else begin
          wc--;
        end
      end else begin
        VCM_ACK = ($urandom_range(0, 15) == 0);
      end
      if (fc == 0) begin
        FRAME_DONE = 1'b1;
        SHARP = tab[cur[13:4]];
        fc = $urandom_range(1, 5);
      end else begin
        fc--;
      end
      tick();
    end
    VCM_ACK = 1'b0;
    FRAME_DONE = 1'b0;
    START = 1'b0;
    check("timeout", 32'(fin), 1);
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check($sformatf("move%0d_s%0d", i, scen), got[i], exp_q[i]);
    check("stable", unstable, 0);
    if (stop_at == 0) begin
      check("n_moves", got.size(), exp_q.size());
      check("best_step", BEST_STEP, exp_best);
      check("best_sharp", BEST_SHARP, exp_sharp);
      check("final_data", VCM_DATA, mk(exp_best));
      check("final_end", VCM_END, 1);
      check("final_req", VCM_REQ, 0);
    end
  endtask

  initial begin
    logic [15:0] d0;
    int          low;
    int          chg;
    int          bchg;
    RESET = 1'b1;
    START = 1'b0;
    FRAME_DONE = 1'b0;
    SHARP = 32'd0;
    VCM_ACK = 1'b0;
    tick();
    check_reset("rst");
    tick();
    RESET = 1'b0;
    tick();
    check_reset("idle");

    for (int s = 0; s < 6; s++) run_search(s, 0);
    run_search(0, 0);

    // Acknowledge withheld while frames keep arriving.
    fill_tab(0);
    START = 1'b1;
    tick();
    START = 1'b0;
    d0 = VCM_DATA;
    check("hold_req0", VCM_REQ, 1);
    low = 0;
    chg = 0;
    bchg = 0;
    for (int i = 0; i < 200; i++) begin
      FRAME_DONE = (i % 3 == 0);
      SHARP = $urandom | 32'd1;
      tick();
      if (VCM_REQ !== 1'b1) low++;
      if (VCM_DATA !== d0) chg++;
      if (BEST_SHARP !== 32'd0 || BEST_STEP !== 10'd0) bchg++;
    end
    FRAME_DONE = 1'b0;
    check("hold_req", low, 0);
    check("hold_data", chg, 0);
    check("hold_best", bchg, 0);
    RESET = 1'b1;
    tick();
    check_reset("hold_rst");
    RESET = 1'b0;

    // Abort partway through the sweep, then search again from scratch.
`ifdef FOCUS_FINE_PASS_EN
    run_search(0, 20);
`else
    run_search(0, 8);
`endif
    RESET = 1'b1;
    tick();
    check_reset("mid_rst");
    RESET = 1'b0;
    tick();
    run_search(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/focus_search_ctrl.md
# focus_search_ctrl

Autofocus search sequencer for the VCM focus path. It steps the lens through a coarse sweep and an optional fine sweep, and for each lens position collects one per-frame sharpness total from the high-frequency statistics datapath. It then parks the lens at the sharpest position. It sits between the pixel statistics stage (sharpness input) and the VCM I2C writer, which consumes `VCM_DATA` through a request/acknowledge handshake.

## Interface
- `MAX_STEP`, 1023: highest legal lens code (10-bit).
- `COARSE_INC`, 64: coarse sweep increment.
- `FINE_INC`, 8: fine sweep increment.
- `SETTLE_FRAMES`, 1: frames discarded after each lens move before measuring.
- `SLEW`, 4'hF: slew/step-mode nibble placed in `VCM_DATA[3:0]`.
- `VIDEO_CLK`  in  1  pixel clock; the only clock.
- `RESET`  in  1  synchronous, active-high reset.
- `START`  in  1  one-cycle pulse that begins a search.
- `FRAME_DONE`  in  1  one-cycle pulse at end of frame; `SHARP` is valid in that cycle.
- `SHARP`  in  32  unsigned sharpness total of the just-finished frame.
- `VCM_ACK`  in  1  one-cycle pulse from the I2C writer when `VCM_DATA` has been written.
- `VCM_REQ`  out  1  write request to the I2C writer.
- `VCM_DATA`  out  16  {2'b00, STEP[9:0], SLEW}.
- `STEP`  out  10  current lens code.
- `BEST_STEP`  out  10  best code found so far.
- `BEST_SHARP`  out  32  sharpness value at `BEST_STEP`.
- `VCM_END`  out  1  1 when idle or done; 0 while searching.

## Operation
- States: IDLE, MOVE, SETTLE, MEASURE, NEXT, FINAL_MOVE, DONE.
- IDLE/DONE + `START` → initialise. STEP=0, BEST_SHARP=0, BEST_STEP=0, phase=COARSE, first=1. Go to MOVE. `START` is ignored in all other states.
- MOVE: drive `VCM_REQ`=1 with `VCM_DATA` built from STEP. On `VCM_ACK`, drop `VCM_REQ` and go to SETTLE, loading settle counter = SETTLE_FRAMES.
- SETTLE: each `FRAME_DONE` decrements the counter. At 0, go to MEASURE. With SETTLE_FRAMES=0, SETTLE passes straight to MEASURE.
- MEASURE: on the next `FRAME_DONE`, update BEST_STEP/BEST_SHARP if `SHARP` > BEST_SHARP or first=1. Clear first, then go to NEXT.
  - The comparison is strict, so a tie keeps the earlier (lower-code) position.
- NEXT, coarse phase: if STEP+COARSE_INC ≤ MAX_STEP, STEP += COARSE_INC and go to MOVE. Otherwise the coarse sweep is finished.
- Fine window: lo = max(0, BEST_STEP−COARSE_INC), hi = min(MAX_STEP, BEST_STEP+COARSE_INC).
  - Set STEP=lo, phase=FINE, go to MOVE.
  - Without the fine-pass feature, go to FINAL_MOVE instead.
- NEXT, fine phase: if STEP+FINE_INC ≤ hi, STEP += FINE_INC and go to MOVE. Otherwise go to FINAL_MOVE.
- The fine pass keeps the BEST from the coarse pass. A fine point re-measured at the same code competes normally.
- FINAL_MOVE: STEP=BEST_STEP, issue the MOVE handshake. On `VCM_ACK`, go to DONE with no settle or measure.
- DONE: `VCM_END`=1. Outputs hold until the next `START` or `RESET`.
- Width rules:
  - Step sums and window bounds are computed in 11 bits before compare/clamp, so there is no wrap at 1023.
  - `SHARP` is compared as 32-bit unsigned.
  - A `FRAME_DONE` outside SETTLE/MEASURE is ignored.
  - A `VCM_ACK` outside MOVE/FINAL_MOVE is ignored.

## Timing
- Reset values: `VCM_REQ`=0, `STEP`=0, `VCM_DATA`={2'b00,10'd0,SLEW}, `BEST_STEP`=0, `BEST_SHARP`=0, `VCM_END`=1, state IDLE.
- `START` in cycle n gives `VCM_REQ`=1 and `VCM_END`=0 in cycle n+1.
- `VCM_DATA` changes only while `VCM_REQ`=0. It is stable for the whole time `VCM_REQ` is high.
- `VCM_ACK` in cycle n gives `VCM_REQ`=0 in cycle n+1. `VCM_REQ` stays high indefinitely until acknowledged.
- The BEST update is visible the cycle after the measuring `FRAME_DONE`.
- Each coarse or fine point costs SETTLE_FRAMES+1 `FRAME_DONE` pulses plus the handshake.
- `RESET` mid-search aborts immediately to the reset values. It does not wait for a pending `VCM_ACK`.

## Configuration
- `FOCUS_FINE_PASS_EN` defined: the fine sweep runs as described.
- `FOCUS_FINE_PASS_EN` undefined:
  - After the coarse sweep, the block goes straight to FINAL_MOVE at the coarse BEST_STEP.
  - The fine-window logic is not built, and `FINE_INC` is unused.

## Test plan
- Defaults with macro, SETTLE_FRAMES=1, ACK 3 cycles after REQ, `SHARP`=1000000−100·|STEP−304|:
  - Required: 16 coarse points (0..960), coarse best 320, 17 fine points (256..384).
  - Final `BEST_STEP`=304, `VCM_DATA`=16'h130F, `VCM_END`=1.
- Same stimulus without `FOCUS_FINE_PASS_EN` → final `BEST_STEP`=320, `VCM_DATA`=16'h140F, after 16 measured points.
- Constant `SHARP`=5000 → the tie rule holds: `BEST_STEP`=0, `BEST_SHARP`=5000, final `VCM_DATA`=16'h000F.
- Peak at code 0 with the macro → fine window clamps to 0..64 (9 points), `BEST_STEP`=0, no STEP wrap.
- Hold `VCM_ACK` off for 200 cycles while pulsing `FRAME_DONE` → `VCM_REQ` stays 1, `VCM_DATA` stays constant, and no measurement or BEST change occurs.
- `RESET` asserted mid-fine-sweep, then `START` → all outputs return to reset values one cycle after reset, and the new search restarts from STEP=0.
